// File: rtl/rv16_csr_pkg.sv
// Shared constants for the rv16 CSR access path: CSR op codes, SYSTEM funct3
// encodings, well-known CSR addresses and the request FSM state type.
package rv16_csr_pkg;

  localparam logic [2:0] OP_RD = 3'b000;
  localparam logic [2:0] OP_RW = 3'b001;
  localparam logic [2:0] OP_RS = 3'b010;
  localparam logic [2:0] OP_RC = 3'b011;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  localparam logic [11:0] CSR_CYCLE   = 12'hC00;
  localparam logic [11:0] CSR_INSTRET = 12'hC02;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_WB   = 2'd3
  } csr_state_e;

  // funct3 000 (ECALL/EBREAK class) and 100 (reserved) are not CSR accesses.
  function automatic logic f3_legal(input logic [2:0] f3);
    return f3[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/rv16_csr_req.sv
// CSR access initiator: one decoded CSR instruction in, one request to the CSR
// file, old value back to writeback. Optional WAIT timeout: RV16_CSR_TIMEOUT_EN.
module rv16_csr_req
  import rv16_csr_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_funct3,
  input  logic [11:0]     i_csr_addr,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [4:0]      i_rs1_idx,
  input  logic [4:0]      i_rd,
  output logic [11:0]     o_csr_addr,
  output logic [31:0]     o_csr_wdata,
  output logic [2:0]      o_csr_op,
  output logic            o_csr_valid,
  input  logic [31:0]     i_csr_rdata,
  input  logic            i_csr_ready,
  output logic            o_wb_valid,
  output logic [4:0]      o_wb_rd,
  output logic [XLEN-1:0] o_wb_data,
  output logic            o_illegal
);

  csr_state_e      state_q, state_d;
  logic [11:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [2:0]      op_q, op_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            illegal_q, illegal_d;
  logic            timeout;

`ifdef RV16_CSR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;

  // Counts completed WAIT cycles; zero on every entry to WAIT.
  always_ff @(posedge clk) begin
    if (!rst_n)                cnt_q <= '0;
    else if (state_q != S_WAIT) cnt_q <= '0;
    else                       cnt_q <= cnt_q + 1'b1;
  end

  assign timeout = (state_q == S_WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    op_d      = op_q;
    rd_d      = rd_q;
    data_d    = data_q;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          if (f3_legal(i_funct3)) begin
            state_d = S_REQ;
            addr_d  = i_csr_addr;
            rd_d    = i_rd;
            // RS/RC with a zero operand index must not write: issue a plain read.
            op_d    = (i_funct3[1] && (i_rs1_idx == 5'd0)) ? OP_RD : {1'b0, i_funct3[1:0]};
            wdata_d = i_funct3[2] ? {27'd0, i_rs1_idx} : 32'(i_rs1_data);
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      S_REQ: state_d = S_WAIT;
      S_WAIT: begin
        if (i_csr_ready) begin
          data_d  = XLEN'(i_csr_rdata);
          state_d = (rd_q != 5'd0) ? S_WB : S_IDLE;
        end else if (timeout) begin
          illegal_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      data_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
      illegal_q <= illegal_d;
    end
  end

  logic req_act, wb_act;
  assign req_act = (state_q == S_REQ) || (state_q == S_WAIT);
  assign wb_act  = (state_q == S_WB);

  assign o_ready     = (state_q == S_IDLE);
  assign o_csr_valid = (state_q == S_REQ);
  assign o_csr_addr  = req_act ? addr_q  : '0;
  assign o_csr_wdata = req_act ? wdata_q : '0;
  assign o_csr_op    = req_act ? op_q    : '0;
  assign o_wb_valid  = wb_act && (rd_q != 5'd0);
  assign o_wb_rd     = wb_act ? rd_q   : '0;
  assign o_wb_data   = wb_act ? data_q : '0;
  assign o_illegal   = illegal_q;

endmodule

// File: tb/tb_rv16_csr_req.sv
// Directed bench for rv16_csr_req with a small CSR-file responder model.
module tb_rv16_csr_req;
  import rv16_csr_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [2:0]  i_funct3;
  logic [11:0] i_csr_addr;
  logic [31:0] i_rs1_data;
  logic [4:0]  i_rs1_idx;
  logic [4:0]  i_rd;
  logic [11:0] o_csr_addr;
  logic [31:0] o_csr_wdata;
  logic [2:0]  o_csr_op;
  logic        o_csr_valid;
  logic [31:0] i_csr_rdata;
  logic        i_csr_ready;
  logic        o_wb_valid;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data;
  logic        o_illegal;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rv16_csr_req #(.XLEN(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_funct3(i_funct3), .i_csr_addr(i_csr_addr), .i_rs1_data(i_rs1_data),
    .i_rs1_idx(i_rs1_idx), .i_rd(i_rd), .o_csr_addr(o_csr_addr),
    .o_csr_wdata(o_csr_wdata), .o_csr_op(o_csr_op), .o_csr_valid(o_csr_valid),
    .i_csr_rdata(i_csr_rdata), .i_csr_ready(i_csr_ready), .o_wb_valid(o_wb_valid),
    .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data), .o_illegal(o_illegal)
  );

  // CSR file model: ready comes rsp_dly cycles after the strobe (0 = silent).
  logic [31:0] mem [0:4095];
  int          rsp_dly = 1;
  int          rsp_cnt = 0;
  logic [31:0] rsp_data = '0;

  assign i_csr_ready = (rsp_cnt == 1);
  assign i_csr_rdata = i_csr_ready ? rsp_data : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (o_csr_valid) begin
      rsp_data <= mem[o_csr_addr];
      rsp_cnt  <= rsp_dly;
      case (o_csr_op)
        OP_RW:   mem[o_csr_addr] <= o_csr_wdata;
        OP_RS:   mem[o_csr_addr] <= mem[o_csr_addr] | o_csr_wdata;
        OP_RC:   mem[o_csr_addr] <= mem[o_csr_addr] & ~o_csr_wdata;
        default: ;
      endcase
    end else if (rsp_cnt > 0) begin
      rsp_cnt <= rsp_cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Presents one instruction for a single accept edge; returns at the
  // negedge of cycle 1.
  task automatic issue(input logic [2:0] f3, input logic [11:0] addr,
                       input logic [31:0] rs1, input logic [4:0] idx, input logic [4:0] rd);
    @(negedge clk);
    i_funct3 = f3; i_csr_addr = addr; i_rs1_data = rs1; i_rs1_idx = idx; i_rd = rd;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(negedge clk);
  endtask

  // Full access with a one-cycle responder, checked cycle by cycle.
  task automatic xact(input string tag, input logic [2:0] f3, input logic [11:0] addr,
                      input logic [31:0] rs1, input logic [4:0] idx, input logic [4:0] rd,
                      input logic [2:0] exp_op, input logic [31:0] exp_wd,
                      input logic [31:0] exp_old);
    rsp_dly = 1;
    issue(f3, addr, rs1, idx, rd);
    chk({tag, ".c1.valid"}, 32'(o_csr_valid), 32'd1);
    chk({tag, ".c1.addr"},  32'(o_csr_addr), 32'(addr));
    chk({tag, ".c1.op"},    32'(o_csr_op), 32'(exp_op));
    chk({tag, ".c1.wdata"}, o_csr_wdata, exp_wd);
    chk({tag, ".c1.ready"}, 32'(o_ready), 32'd0);
    @(negedge clk);
    chk({tag, ".c2.valid"}, 32'(o_csr_valid), 32'd0);
    chk({tag, ".c2.op"},    32'(o_csr_op), 32'(exp_op));
    chk({tag, ".c2.wdata"}, o_csr_wdata, exp_wd);
    @(negedge clk);
    chk({tag, ".c3.wbv"},   32'(o_wb_valid), (rd != 5'd0) ? 32'd1 : 32'd0);
    chk({tag, ".c3.ready"}, 32'(o_ready), (rd == 5'd0) ? 32'd1 : 32'd0);
    if (rd != 5'd0) begin
      chk({tag, ".c3.rd"},   32'(o_wb_rd), 32'(rd));
      chk({tag, ".c3.data"}, o_wb_data, exp_old);
    end
    @(negedge clk);
    chk({tag, ".c4.ready"}, 32'(o_ready), 32'd1);
    chk({tag, ".c4.wbv"},   32'(o_wb_valid), 32'd0);
  endtask

  initial begin
    int ill_cnt, ill_at, wb_seen, cv_seen;
    for (int a = 0; a < 4096; a++) mem[a] = '0;
    mem[CSR_MIE] = 32'h14;
    rst_n = 1'b0; i_valid = 1'b0; i_funct3 = '0; i_csr_addr = '0;
    i_rs1_data = '0; i_rs1_idx = '0; i_rd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.valid", 32'(o_csr_valid), 32'd0);
    chk("rst.wbv",   32'(o_wb_valid), 32'd0);
    chk("rst.ill",   32'(o_illegal), 32'd0);
    chk("rst.addr",  32'(o_csr_addr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.ready", 32'(o_ready), 32'd1);

    // CSRRW x5, mstatus, 0x88 then read back through CSRRS x6 with rs1 = x0.
    xact("rw_mstatus", F3_CSRRW, CSR_MSTATUS, 32'h88, 5'd1, 5'd5, OP_RW, 32'h88, 32'h0);
    xact("rd_mstatus", F3_CSRRS, CSR_MSTATUS, 32'hFFFF_FFFF, 5'd0, 5'd6, OP_RD, 32'hFFFF_FFFF, 32'h88);
    // Immediate forms on mie (preloaded 0x14).
    xact("rsi_z0",  F3_CSRRSI, CSR_MIE, 32'hAAAA_5555, 5'd0, 5'd7, OP_RD, 32'h0, 32'h14);
    chk("rsi_z0.mie", mem[CSR_MIE], 32'h14);
    xact("rci_z4",  F3_CSRRCI, CSR_MIE, 32'hAAAA_5555, 5'd4, 5'd8, OP_RC, 32'h4, 32'h14);
    chk("rci_z4.mie", mem[CSR_MIE], 32'h10);
    xact("rs_mie",  F3_CSRRS, CSR_MIE, 32'h1, 5'd3, 5'd9, OP_RS, 32'h1, 32'h10);
    chk("rs_mie.mie", mem[CSR_MIE], 32'h11);
    xact("rwi_mepc", F3_CSRRWI, CSR_MEPC, 32'h0, 5'd31, 5'd10, OP_RW, 32'h1F, 32'h0);
    // rd = x0: access completes but never writes back.
    xact("rw_x0", F3_CSRRW, CSR_MTVEC, 32'h100, 5'd2, 5'd0, OP_RW, 32'h100, 32'h0);
    chk("rw_x0.mtvec", mem[CSR_MTVEC], 32'h100);

    // Illegal funct3 100: one-cycle illegal pulse, no request.
    issue(3'b100, CSR_MSTATUS, 32'h1, 5'd1, 5'd3);
    chk("ill.c1.ill",   32'(o_illegal), 32'd1);
    chk("ill.c1.valid", 32'(o_csr_valid), 32'd0);
    chk("ill.c1.ready", 32'(o_ready), 32'd1);
    @(negedge clk);
    chk("ill.c2.ill",   32'(o_illegal), 32'd0);
    chk("ill.c2.valid", 32'(o_csr_valid), 32'd0);

    // Reset during WAIT; the late ready (cycle 5) must be ignored.
    rsp_dly = 4;
    issue(F3_CSRRW, CSR_MCAUSE, 32'h7, 5'd1, 5'd4);
    @(negedge clk);
    chk("rstw.c2.ready", 32'(o_ready), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wb_seen = 0; cv_seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (o_wb_valid) wb_seen++;
      if (o_csr_valid) cv_seen++;
      @(negedge clk);
    end
    chk("rstw.wbv",   32'(wb_seen), 32'd0);
    chk("rstw.valid", 32'(cv_seen), 32'd0);
    chk("rstw.ready", 32'(o_ready), 32'd1);
    chk("rstw.addr",  32'(o_csr_addr), 32'd0);
    chk("rstw.wdata", o_csr_wdata, 32'd0);

    // Silent responder.
    rsp_dly = 0;
    issue(F3_CSRRW, CSR_MTVAL, 32'h5, 5'd1, 5'd11);
    ill_cnt = 0; ill_at = 0; wb_seen = 0;
    for (int c = 2; c <= 24; c++) begin
      @(negedge clk);
      if (o_illegal) begin ill_cnt++; ill_at = c; end
      if (o_wb_valid) wb_seen++;
    end
`ifdef RV16_CSR_TIMEOUT_EN
    chk("to.ill_cnt", 32'(ill_cnt), 32'd1);
    chk("to.ill_at",  32'(ill_at), 32'd18);
    chk("to.wbv",     32'(wb_seen), 32'd0);
    chk("to.ready",   32'(o_ready), 32'd1);
`else
    chk("nto.ill",   32'(ill_cnt), 32'd0);
    chk("nto.wbv",   32'(wb_seen), 32'd0);
    chk("nto.ready", 32'(o_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("nto.rec", 32'(o_ready), 32'd1);
`endif
    // Next instruction proceeds normally; mtval was written 0x5 before the stall.
    xact("after", F3_CSRRC, CSR_MTVAL, 32'h1, 5'd6, 5'd12, OP_RC, 32'h1, 32'h5);
    chk("after.mtval", mem[CSR_MTVAL], 32'h4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
